mem_sp_arb: RTL and testbench
=============================

# mem_sp_arb

Round-robin arbiter and sequencer that shares one single-port SRAM wrapper instance (`mem_sp_sky130`) between NUM_REQ requesters.

- Sits directly in front of the memory and accepts read/write commands over valid/ready.
- Drives the wrapper's addr/wen/ren/wdata from registers.
- Holds a read's address and ren for the wrapper's two-cycle read.
- Returns read data with the requester's one-hot ID.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- DATA_BIT, `IDATA_WIDTH*`MAC_MULT_NUM: word width; must match the memory instance.
- DEPTH, 128: memory depth in words.
- ADDR_BIT, $clog2(DEPTH): address width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_wen  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_BIT  flattened; requester i at [i*ADDR_BIT +: ADDR_BIT].
- req_wdata  in  NUM_REQ*DATA_BIT  flattened write data.
- rsp_valid  out  1  read data valid, one cycle.
- rsp_id  out  NUM_REQ  one-hot owner of rsp_data.
- rsp_data  out  DATA_BIT  read data.
- mem_addr  out  ADDR_BIT  to the wrapper addr.
- mem_wen  out  1  to the wrapper wen.
- mem_ren  out  1  to the wrapper ren.
- mem_wdata  out  DATA_BIT  to the wrapper wdata.
- mem_rdata  in  DATA_BIT  from the wrapper rdata, which is registered inside the wrapper.

## Operation
- Handshake: a command from requester i transfers in cycle G when req_valid[i] & req_ready[i]. Requester fields must be stable while valid and not ready.
- Arbitration:
  - The arbiter considers only requesters with req_valid=1.
  - Search order starts at rr_ptr and wraps modulo NUM_REQ.
  - At most one req_ready bit is high per cycle.
  - After each transfer, rr_ptr = winner+1 mod NUM_REQ.
- Accept window: grants are made only in states IDLE and HOLD. In state RD, req_ready is 0.
- FSM:
  - IDLE, read accepted → RD.
  - IDLE, write accepted → IDLE.
  - IDLE, no transfer → IDLE; mem_wen and mem_ren are loaded to 0.
  - RD → HOLD unconditionally. mem_* registers hold the read command.
  - HOLD, new command accepted → treated as from IDLE.
  - HOLD, no transfer → IDLE. The command registers clear wen/ren to 0.
- Command registers: on a transfer in cycle G, the winner's addr, wen, ren=~wen and wdata load at the end of G, so the memory sees the command during cycle G+1.
- Read hold: a read keeps mem_addr and mem_ren=1, with mem_wen=0, for cycles G+1 and G+2. This is required because the wrapper's output mux samples addr and ren at the second edge.
- Response pipe:
  - The read owner ID is carried in a 2-stage shift register.
  - rsp_valid=1 and rsp_id=owner in cycle G+3, with rsp_data=mem_rdata passed through combinationally.
  - rsp_data is don't-care when rsp_valid=0.
- Write-after-read ordering:
  - A write accepted in HOLD reaches the memory after the read's second edge, so the read returns pre-write data.
  - A read after a write to the same address returns the new data.
- Reset:
  - All outputs go to 0: req_ready, rsp_valid, rsp_id, mem_wen, mem_ren, mem_addr, mem_wdata.
  - FSM goes to IDLE and rr_ptr to 0.
  - An in-flight read is dropped and produces no rsp_valid.

## Timing
- Write: transfer at G, memory write at the edge ending G+1. Throughput is 1 per cycle.
- Read: transfer at G, response at G+3. Throughput is 1 per 2 cycles; back-to-back reads transfer at G and G+2.
- req_ready is combinational from req_valid, FSM state and rr_ptr. There is no combinational path from mem_rdata to req_ready.
- In the first cycle after rst deasserts, the FSM is IDLE and accepting.

## Configuration
- MEM_ARB_WR_PRIORITY_EN defined:
  - If any valid requester has req_wen=1, only writers compete, using the same round-robin pointer.
  - Reads win only when no write is pending. Readers may starve under continuous writes.
- Undefined: pure round-robin over all valid requesters, regardless of type.

## Test plan
- Reset mid-read: read accepted at G, rst high at G+1 → no rsp_valid at G+3; all outputs 0 during reset; a read to a fresh address after reset works.
- Single write then read: requester 0 writes addr 5 = 0xA5 at G0 and reads addr 5 at G0+1 → mem_ren high for 2 cycles; rsp_valid with rsp_id=4'b0001 and rsp_data=0xA5 at G0+4.
- Fairness: all 4 requesters hold reads continuously → grants 0,1,2,3,0 at cycles G, G+2, G+4, G+6, G+8; req_ready stays 0 in every RD cycle.
- Write burst: requester 2 writes addr 0..7 continuously → 8 transfers in 8 consecutive cycles; reads afterwards return the written data.
- Write-after-read hazard: requester 1 reads addr 9 (old value 0x11); requester 3's write of 0x22 to addr 9 is accepted in HOLD → rsp_data=0x11; a following read returns 0x22.
- MEM_ARB_WR_PRIORITY_EN: requester 0 reads and requester 1 writes, both valid, rr_ptr=0 → with macro requester 1 is granted first; without it requester 0 is.

Source files
------------

// File: rtl/mem_sp_arb.sv
// Round-robin arbiter/sequencer sharing one single-port SRAM wrapper.
// Define MEM_ARB_WR_PRIORITY_EN to let pending writes win over reads.
`ifndef IDATA_WIDTH
`define IDATA_WIDTH 8
`endif
`ifndef MAC_MULT_NUM
`define MAC_MULT_NUM 4
`endif

module mem_sp_arb #(
   parameter int NUM_REQ  = 4,
   parameter int DATA_BIT = `IDATA_WIDTH * `MAC_MULT_NUM,
   parameter int DEPTH    = 128,
   parameter int ADDR_BIT = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ-1:0]           req_wen,
   input  logic [NUM_REQ*ADDR_BIT-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_BIT-1:0]  req_wdata,
   output logic                         rsp_valid,
   output logic [NUM_REQ-1:0]           rsp_id,
   output logic [DATA_BIT-1:0]          rsp_data,
   output logic [ADDR_BIT-1:0]          mem_addr,
   output logic                         mem_wen,
   output logic                         mem_ren,
   output logic [DATA_BIT-1:0]          mem_wdata,
   input  logic [DATA_BIT-1:0]          mem_rdata
);

   localparam int PW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_HOLD
   } state_t;

   state_t                state_q;
   logic [PW-1:0]         rr_ptr_q;
   logic [ADDR_BIT-1:0]   addr_q;
   logic                  wen_q;
   logic                  ren_q;
   logic [DATA_BIT-1:0]   wdata_q;
   logic [NUM_REQ-1:0]    own_q;
   logic                  s1_v_q;
   logic [NUM_REQ-1:0]    s1_id_q;
   logic                  s2_v_q;
   logic [NUM_REQ-1:0]    s2_id_q;

   logic [NUM_REQ-1:0]    elig;
   logic [NUM_REQ-1:0]    gnt;
   logic [PW-1:0]         win;
   logic                  accept;
   logic                  xfer;
   logic [ADDR_BIT-1:0]   cmd_addr_d;
   logic [DATA_BIT-1:0]   cmd_wdata_d;
   logic                  cmd_wen_d;
   logic [PW-1:0]         rr_ptr_d;

   always_comb begin
      elig = req_valid;
`ifdef MEM_ARB_WR_PRIORITY_EN
      if (|(req_valid & req_wen)) begin
         elig = req_valid & req_wen;
      end
`else
`endif
      gnt = '0;
      win = '0;
      // Descending scan: the last hit is the closest to rr_ptr.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (elig[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
            win = PW'((int'(rr_ptr_q) + k) % NUM_REQ);
            gnt = '0;
            gnt[(int'(rr_ptr_q) + k) % NUM_REQ] = 1'b1;
         end
      end
   end

   assign accept      = ~rst & (state_q != S_RD);
   assign req_ready   = accept ? gnt : '0;
   assign xfer        = |req_ready;
   assign cmd_addr_d  = req_addr[win*ADDR_BIT +: ADDR_BIT];
   assign cmd_wdata_d = req_wdata[win*DATA_BIT +: DATA_BIT];
   assign cmd_wen_d   = req_wen[win];
   assign rr_ptr_d    = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         addr_q   <= '0;
         wen_q    <= 1'b0;
         ren_q    <= 1'b0;
         wdata_q  <= '0;
         own_q    <= '0;
         s1_v_q   <= 1'b0;
         s1_id_q  <= '0;
         s2_v_q   <= 1'b0;
         s2_id_q  <= '0;
      end else begin
         s2_v_q  <= s1_v_q;
         s2_id_q <= s1_id_q;
         s1_v_q  <= 1'b0;
         s1_id_q <= '0;
         case (state_q)
            S_RD: begin
               // Command registers hold so the wrapper sees the read twice.
               state_q <= S_HOLD;
               s1_v_q  <= 1'b1;
               s1_id_q <= own_q;
            end
            default: begin
               if (xfer) begin
                  addr_q   <= cmd_addr_d;
                  wen_q    <= cmd_wen_d;
                  ren_q    <= ~cmd_wen_d;
                  wdata_q  <= cmd_wdata_d;
                  own_q    <= gnt;
                  rr_ptr_q <= rr_ptr_d;
                  state_q  <= cmd_wen_d ? S_IDLE : S_RD;
               end else begin
                  wen_q   <= 1'b0;
                  ren_q   <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wen   = wen_q;
   assign mem_ren   = ren_q;
   assign mem_wdata = wdata_q;
   assign rsp_valid = s2_v_q;
   assign rsp_id    = s2_id_q;
   assign rsp_data  = mem_rdata;

endmodule

// File: tb/tb_mem_sp_arb.sv
// Bench for mem_sp_arb: directed scenarios plus random traffic against
// an in-order memory reference; includes a registered-read SRAM model.
module tb_mem_sp_arb;

   localparam int NR    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 128;
   localparam int AW    = 7;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     req_valid = '0;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     req_wen = '0;
   logic [NR*AW-1:0]  req_addr = '0;
   logic [NR*DW-1:0]  req_wdata = '0;
   logic              rsp_valid;
   logic [NR-1:0]     rsp_id;
   logic [DW-1:0]     rsp_data;
   logic [AW-1:0]     mem_addr;
   logic              mem_wen;
   logic              mem_ren;
   logic [DW-1:0]     mem_wdata;
   logic [DW-1:0]     mem_rdata;

   mem_sp_arb #(
      .NUM_REQ(NR),
      .DATA_BIT(DW),
      .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_wen(req_wen),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_id(rsp_id),
      .rsp_data(rsp_data),
      .mem_addr(mem_addr),
      .mem_wen(mem_wen),
      .mem_ren(mem_ren),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] pat(int i);
      return 32'hC0DE0000 | 32'(i);
   endfunction

   // SRAM wrapper model: write and registered read on the clock edge
   logic [DW-1:0] mem_arr [DEPTH];
   bit            load_pat = 1'b1;

   always @(posedge clk) begin
      if (load_pat) begin
         for (int i = 0; i < DEPTH; i++) mem_arr[i] <= pat(i);
      end else begin
         if (mem_wen) mem_arr[mem_addr] <= mem_wdata;
         if (mem_ren) mem_rdata <= mem_arr[mem_addr];
      end
   end

   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            ptr = 0;
   bit            busy = 1'b0;
   int            last_rd = -10;
   int            last_wr = -10;
   logic [AW-1:0] rd_a, wr_a;
   logic [DW-1:0] wr_d;
   logic [DW-1:0] ref_mem [DEPTH];
   int            q_due [$];
   logic [NR-1:0] q_id [$];
   logic [DW-1:0] q_dat [$];
   logic [DW-1:0] rsp_log [$];
   int            gcyc [$];
   logic [NR-1:0] gid [$];
   logic [NR-1:0] acc = '0;
   logic [NR-1:0] dut_rdy = '0;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(int i, bit v, bit w, int a, logic [DW-1:0] d);
      req_valid[i] = v;
      req_wen[i] = w;
      req_addr[i*AW +: AW] = AW'(a);
      req_wdata[i*DW +: DW] = d;
   endtask

   // One clock: check the DUT against the reference, then advance.
   task automatic step();
      logic [NR-1:0] elig, er;
      logic [AW-1:0] a;
      int            win;
      bit            found, ev, x_ren, x_wen;
      @(negedge clk);
      elig = req_valid;
`ifdef MEM_ARB_WR_PRIORITY_EN
      if (|(req_valid & req_wen)) elig = req_valid & req_wen;
`else
`endif
      er = '0;
      found = 1'b0;
      win = 0;
      if (!busy) begin
         for (int k = 0; k < NR; k++) begin
            if (!found && elig[(ptr + k) % NR]) begin
               found = 1'b1;
               win = (ptr + k) % NR;
               er[win] = 1'b1;
            end
         end
      end
      dut_rdy = req_ready;
      chk("req_ready", req_ready, er);
      ev = (q_due.size() > 0) && (q_due[0] == cyc);
      chk("rsp_valid", rsp_valid, ev);
      if (ev) begin
         chk("rsp_id", rsp_id, q_id[0]);
         chk("rsp_data", rsp_data, q_dat[0]);
         rsp_log.push_back(rsp_data);
         void'(q_due.pop_front());
         void'(q_id.pop_front());
         void'(q_dat.pop_front());
      end
      x_ren = (cyc == last_rd + 1) || (cyc == last_rd + 2);
      x_wen = (cyc == last_wr + 1);
      chk("mem_ren", mem_ren, x_ren);
      chk("mem_wen", mem_wen, x_wen);
      if (x_ren) chk("mem_addr_rd", mem_addr, rd_a);
      if (x_wen) begin
         chk("mem_addr_wr", mem_addr, wr_a);
         chk("mem_wdata", mem_wdata, wr_d);
      end
      acc = er;
      busy = 1'b0;
      if (found) begin
         a = req_addr[win*AW +: AW];
         ptr = (win + 1) % NR;
         gcyc.push_back(cyc);
         gid.push_back(er);
         if (req_wen[win]) begin
            ref_mem[a] = req_wdata[win*DW +: DW];
            last_wr = cyc;
            wr_a = a;
            wr_d = req_wdata[win*DW +: DW];
         end else begin
            q_due.push_back(cyc + 3);
            q_id.push_back(er);
            q_dat.push_back(ref_mem[a]);
            last_rd = cyc;
            rd_a = a;
            busy = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic issue(int i, bit w, int a, logic [DW-1:0] d);
      bit got;
      got = 1'b0;
      set_req(i, 1'b1, w, a, d);
      for (int n = 0; n < 20 && !got; n++) begin
         step();
         got = acc[i];
      end
      if (!got) begin
         total++;
         bad++;
         $error("FAIL issue_timeout req=%0d observed=none expected=grant", i);
      end
      req_valid[i] = 1'b0;
   endtask

   task automatic drain(int n);
      req_valid = '0;
      repeat (n) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_mem_wen", mem_wen, 0);
      chk("rst_mem_ren", mem_ren, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      req_valid = '0;
      q_due.delete();
      q_id.delete();
      q_dat.delete();
      ptr = 0;
      busy = 1'b0;
      last_rd = -10;
      last_wr = -10;
      rst = 1'b0;
   endtask

   logic [NR-1:0] fexp [5];
   logic [NR-1:0] prio_exp;

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
      do_reset();
      load_pat = 1'b0;

      // single write then read of the same word
      issue(0, 1'b1, 5, 32'hA5);
      issue(0, 1'b0, 5, 0);
      drain(4);
      chk("wr_rd_data", rsp_log[$], 32'hA5);

      // fairness with all requesters reading
      do_reset();
      gcyc.delete();
      gid.delete();
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 10 + i, 0);
      repeat (9) step();
      fexp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      chk("fair_n", gid.size(), 5);
      for (int k = 0; k < 5 && k < gid.size(); k++) begin
         chk("fair_id", gid[k], fexp[k]);
         chk("fair_gap", gcyc[k] - gcyc[0], 2 * k);
      end
      drain(4);

      // write burst then read back
      for (int j = 0; j < 8; j++) begin
         set_req(2, 1'b1, 1'b1, j, 32'hB00 + j);
         step();
         chk("burst_acc", acc, 4'b0100);
      end
      req_valid = '0;
      for (int j = 0; j < 8; j++) issue(0, 1'b0, j, 0);
      drain(4);
      chk("burst_rd7", rsp_log[$], 32'hB07);

      // write accepted in HOLD after a read of the same word
      issue(3, 1'b1, 9, 32'h11);
      issue(1, 1'b0, 9, 0);
      set_req(3, 1'b1, 1'b1, 9, 32'h22);
      step();
      step();
      chk("war_acc", acc, 4'b1000);
      req_valid = '0;
      issue(1, 1'b0, 9, 0);
      drain(5);
      chk("war_old", rsp_log[$-1], 32'h11);
      chk("war_new", rsp_log[$], 32'h22);

      // write priority option
      do_reset();
      set_req(0, 1'b1, 1'b0, 3, 0);
      set_req(1, 1'b1, 1'b1, 4, 32'h44);
`ifdef MEM_ARB_WR_PRIORITY_EN
      prio_exp = 4'b0010;
`else
      prio_exp = 4'b0001;
`endif
      step();
      chk("prio", dut_rdy, prio_exp);
      req_valid = req_valid & ~acc;
      repeat (6) begin
         step();
         req_valid = req_valid & ~acc;
      end
      drain(4);

      // reset during a read drops the response
      set_req(2, 1'b1, 1'b0, 20, 0);
      step();
      chk("rst_rd_acc", acc, 4'b0100);
      req_valid = '0;
      do_reset();
      drain(4);
      issue(2, 1'b0, 100, 0);
      drain(4);
      chk("post_rst_data", rsp_log[$], pat(100));

      // random traffic
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NR; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
               set_req(i, 1'b1, 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 15)), $urandom);
            end
         end
         step();
         req_valid = req_valid & ~acc;
      end
      drain(5);
      chk("rand_drained", q_due.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
